// File: rtl/move_cmd_scheduler_if.sv
// move_cmd_scheduler_if: key, level and drawer handshake signals around the move command scheduler
interface move_cmd_scheduler_if;
  logic [1:0] mode;
  logic [2:0] level;
  logic keyDrop, keyLeft, keyRight, keyDown, pieceActive;
  logic [3:0] changeblock;
  logic issued, rejected;
  modport master (output mode, level, keyDrop, keyLeft, keyRight, keyDown, pieceActive, input changeblock, issued, rejected);
  modport slave (input mode, level, keyDrop, keyLeft, keyRight, keyDown, pieceActive, output changeblock, issued, rejected);
endinterface

// File: rtl/move_cmd_scheduler.sv
// move_cmd_scheduler: arbitrates key and gravity moves into drawer commands; MOVE_AUTO_REPEAT_EN adds key auto-repeat
module move_cmd_scheduler #(
  parameter int GRAV_W = 26,
  parameter logic [GRAV_W-1:0] GRAV_PERIOD = 26'd50000000,
  parameter logic [3:0] HOLD = 4'd3
`ifdef MOVE_AUTO_REPEAT_EN
  , parameter logic [23:0] REPEAT_DELAY = 24'd15000000,
  parameter logic [23:0] REPEAT_RATE = 24'd5000000
`endif
) (
  input logic CLOCK_50,
  input logic Resetn,
  move_cmd_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READY, ISSUE, BUSY} stateT;
  stateT state;
  logic [3:0] keys, keyQ, rise;
  logic [4:0] pend, sel, pick, set, clr;
  logic [2:0] rep;
  logic [GRAV_W-1:0] gravCnt, period, lastCnt;
  logic [3:0] holdCnt;
  logic play, running, tick, accept, reject;

  function automatic logic [3:0] codeOf(input logic [4:0] m);
    return m[4] ? 4'b0010 : |m[3:2] ? 4'b0101 : m[1] ? 4'b0011 : m[0] ? 4'b0100 : 4'b0001;
  endfunction

`ifdef MOVE_AUTO_REPEAT_EN
  logic [2:0] alone;
  assign alone = {bus.keyDown, bus.keyLeft & ~bus.keyRight, bus.keyRight & ~bus.keyLeft};
  for (genvar i = 0; i < 3; i++) begin : gRep
    logic [23:0] cnt;
    logic started;
    assign rep[i] = alone[i] && cnt == (started ? REPEAT_RATE : REPEAT_DELAY) - 24'd1;
    always_ff @(posedge CLOCK_50 or negedge Resetn)
      if (!Resetn) begin
        cnt <= '0;
        started <= 1'b0;
      end else if (!alone[i]) begin
        cnt <= '0;
        started <= 1'b0;
      end else if (rep[i]) begin
        cnt <= '0;
        started <= 1'b1;
      end else cnt <= cnt + 24'd1;
  end
`else
  assign rep = 3'b000;
`endif

  // pending bit order: {drop, grav, down, left, right}
  always_comb begin
    keys = {bus.keyDrop, bus.keyLeft, bus.keyRight, bus.keyDown};
    rise = keys & ~keyQ;
    play = bus.mode == 2'b01;
    running = state != IDLE;
    period = GRAV_PERIOD >> bus.level;
    lastCnt = period == '0 ? '0 : period - GRAV_W'(1);
    tick = running && gravCnt >= lastCnt;
    set = {rise[3], tick, rise[0] | rep[2], (rise[2] & ~rise[1]) | rep[1], (rise[1] & ~rise[2]) | rep[0]};
    pick = pend[4] ? 5'b10000 : pend[3] ? 5'b01000 : pend[2] ? 5'b00100 : pend[1] ? 5'b00010 : {4'b0000, pend[0]};
    accept = play && state == ISSUE && !bus.pieceActive;
    reject = play && state == ISSUE && bus.pieceActive && holdCnt == 4'd1;
    clr = accept ? (sel[4] ? 5'b11111 : |sel[3:2] ? 5'b01100 : sel) : reject ? sel : 5'b00000;
  end

  assign bus.issued = accept;
  assign bus.rejected = reject;

  always_ff @(posedge CLOCK_50 or negedge Resetn)
    if (!Resetn) begin
      state <= IDLE;
      keyQ <= '0;
      pend <= '0;
      sel <= '0;
      gravCnt <= '0;
      holdCnt <= '0;
      bus.changeblock <= 4'b0000;
    end else begin
      keyQ <= keys;
      if (!play) begin
        state <= IDLE;
        pend <= '0;
        sel <= '0;
        gravCnt <= '0;
        holdCnt <= '0;
        bus.changeblock <= 4'b0000;
      end else begin
        pend <= (pend & ~clr) | set;
        gravCnt <= (accept && |sel[4:2]) || tick ? '0 : running ? gravCnt + GRAV_W'(1) : gravCnt;
        case (state)
          IDLE: begin
            state <= READY;
            bus.changeblock <= 4'b0001;
          end
          READY: if (bus.pieceActive && |pend) begin
            sel <= pick;
            holdCnt <= HOLD;
            state <= ISSUE;
            bus.changeblock <= codeOf(pick);
          end
          ISSUE: begin
            holdCnt <= holdCnt - 4'd1;
            if (accept || reject) begin
              state <= accept ? BUSY : READY;
              bus.changeblock <= 4'b0001;
            end
          end
          BUSY: if (bus.pieceActive) state <= READY;
        endcase
      end
    end
endmodule

// File: tb/tb_move_cmd_scheduler.sv
// tb_move_cmd_scheduler: directed checks of arbitration, gravity, rejection, cancel and reset behaviour
module tb_move_cmd_scheduler;
  logic CLOCK_50, Resetn;
  int checks = 0, failures = 0, nRight = 0;
  move_cmd_scheduler_if bus();

  move_cmd_scheduler #(
    .GRAV_PERIOD(26'd16),
    .HOLD(4'd3)
`ifdef MOVE_AUTO_REPEAT_EN
    , .REPEAT_DELAY(24'd8),
    .REPEAT_RATE(24'd4)
`endif
  ) dut (.CLOCK_50(CLOCK_50), .Resetn(Resetn), .bus(bus));

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chkPulse(input string tag, input logic iss, input logic rej);
    chk({tag, "_issued"}, {3'b000, bus.issued}, {3'b000, iss});
    chk({tag, "_rejected"}, {3'b000, bus.rejected}, {3'b000, rej});
  endtask

  initial begin
    Resetn = 1'b0;
    bus.mode = 2'b00;
    bus.level = 3'd0;
    {bus.keyDrop, bus.keyLeft, bus.keyRight, bus.keyDown} = 4'b0000;
    bus.pieceActive = 1'b1;
    step(2);
    chk("reset_cb", bus.changeblock, 4'b0000);
    chkPulse("reset", 1'b0, 1'b0);
    Resetn = 1'b1;
    step(3);
    chk("idle_mode00", bus.changeblock, 4'b0000);
    bus.mode = 2'b01;
    step(1);
    chk("ready", bus.changeblock, 4'b0001);
    step(16);
    chk("grav_pre", bus.changeblock, 4'b0001);
    step(1);
    chk("grav_tick", bus.changeblock, 4'b0101);
    chkPulse("grav_hold", 1'b0, 1'b0);
    bus.pieceActive = 1'b0;
    #1 chkPulse("grav_accept", 1'b1, 1'b0);
    step(1);
    chk("busy", bus.changeblock, 4'b0001);
    chkPulse("busy", 1'b0, 1'b0);
    bus.pieceActive = 1'b1;
    bus.level = 3'd2;
    step(4);
    chk("l2_pre", bus.changeblock, 4'b0001);
    step(1);
    chk("l2_tick", bus.changeblock, 4'b0101);
    step(1);
    chkPulse("l2_hold", 1'b0, 1'b0);
    step(1);
    chk("l2_hold_cb", bus.changeblock, 4'b0101);
    chkPulse("l2_timeout", 1'b0, 1'b1);
    step(1);
    chk("l2_back", bus.changeblock, 4'b0001);
    step(1);
    chk("l2_retick", bus.changeblock, 4'b0101);
    bus.mode = 2'b10;
    #1 chkPulse("mode_exit", 1'b0, 1'b0);
    step(1);
    chk("mode_exit_cb", bus.changeblock, 4'b0000);
    bus.mode = 2'b01;
    bus.level = 3'd0;
    step(1);
    chk("resume", bus.changeblock, 4'b0001);
    step(5);
    chk("resume_empty", bus.changeblock, 4'b0001);
    bus.keyLeft = 1'b1;
    step(1);
    chk("left_latency", bus.changeblock, 4'b0001);
    step(1);
    chk("left_issue", bus.changeblock, 4'b0011);
    step(2);
    chk("left_hold", bus.changeblock, 4'b0011);
    chkPulse("left_timeout", 1'b0, 1'b1);
    step(1);
    chk("left_back", bus.changeblock, 4'b0001);
    chkPulse("left_back", 1'b0, 1'b0);
    step(3);
    chk("left_cleared", bus.changeblock, 4'b0001);
    bus.keyLeft = 1'b0;
    bus.mode = 2'b00;
    step(1);
    bus.mode = 2'b01;
    step(1);
    bus.keyLeft = 1'b1;
    bus.keyDrop = 1'b1;
    step(2);
    chk("prio_drop", bus.changeblock, 4'b0010);
    bus.pieceActive = 1'b0;
    #1 chkPulse("drop_accept", 1'b1, 1'b0);
    step(1);
    chk("drop_busy", bus.changeblock, 4'b0001);
    bus.pieceActive = 1'b1;
    step(1);
    chk("drop_ready", bus.changeblock, 4'b0001);
    step(3);
    chk("left_dropped", bus.changeblock, 4'b0001);
    {bus.keyDrop, bus.keyLeft} = 2'b00;
    bus.mode = 2'b00;
    step(1);
    bus.mode = 2'b01;
    step(1);
    bus.keyLeft = 1'b1;
    bus.keyRight = 1'b1;
    step(4);
    chk("cancel", bus.changeblock, 4'b0001);
    {bus.keyLeft, bus.keyRight} = 2'b00;
    step(1);
    bus.keyRight = 1'b1;
    step(2);
    chk("right_issue", bus.changeblock, 4'b0100);
    bus.pieceActive = 1'b0;
    #1 chkPulse("right_accept", 1'b1, 1'b0);
    step(1);
    bus.pieceActive = 1'b1;
    bus.keyRight = 1'b0;
    bus.keyDown = 1'b1;
    step(2);
    chk("down_issue", bus.changeblock, 4'b0101);
    bus.pieceActive = 1'b0;
    step(1);
    bus.pieceActive = 1'b1;
    bus.keyDown = 1'b0;
    step(1);
    bus.keyLeft = 1'b1;
    step(2);
    chk("pre_reset", bus.changeblock, 4'b0011);
    Resetn = 1'b0;
    bus.mode = 2'b00;
    bus.keyLeft = 1'b0;
    #1 chk("async_reset_cb", bus.changeblock, 4'b0000);
    chkPulse("async_reset", 1'b0, 1'b0);
    step(1);
    Resetn = 1'b1;
    step(2);
    chk("post_reset_idle", bus.changeblock, 4'b0000);
`ifdef MOVE_AUTO_REPEAT_EN
    bus.mode = 2'b01;
    step(1);
    bus.keyRight = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) bus.keyRight = 1'b0;
      bus.pieceActive = bus.changeblock != 4'b0100;
      #1 if (bus.issued && bus.changeblock == 4'b0100) nRight++;
      step(1);
    end
    chk("repeat_count", {3'b000, nRight >= 4}, 4'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
